core_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit; sits beside the single-cycle integer ALU in the EX stage.
- Handles the eight R-type M instructions: opcode 0110011, funct7 0000001.
- Takes operands on a start pulse and holds the pipeline with o_busy.
- Returns a 32-bit result with a one-cycle o_done pulse after a fixed latency.

---
 rtl/core_muldiv.sv | 208 ++++++++++++++++++++
 tb/tb_core_muldiv.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : core_muldiv
// Brief    : Iterative RV32M multiply/divide unit. Shift-add multiply and
//            restoring divide, one bit per cycle, fixed 33-cycle latency
//            from accept to o_done.
// Revision : 1.0 - initial release
// ============================================================================
module core_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [6:0]  i_opcode,
    input  logic [6:0]  i_funct7,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_num1u,
    input  logic [31:0] i_num2u,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_res
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [6:0] C_OPCODE_OP = 7'b0110011;
    localparam logic [6:0] C_FUNCT7_M  = 7'b0000001;
    localparam logic [4:0] C_LAST_ITER = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [31:0] r_num1;      // raw rs1, returned untouched for REM by zero
    logic        r_neg1;
    logic        r_neg2;
    logic        r_div_by_zero;
    logic        r_ovf;
    logic [31:0] r_hi;        // product high half / partial remainder
    logic [31:0] r_lo;        // product low half (multiplier) / quotient (dividend)
    logic [31:0] r_mcand;     // multiplicand / divisor magnitude
    logic        r_done;
    logic [31:0] r_res;

    logic        w_accept;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_prod_s;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_result;

    assign w_accept = (r_state == S_IDLE) && i_start &&
                      (i_opcode == C_OPCODE_OP) && (i_funct7 == C_FUNCT7_M);

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 only for MUL/MULH/DIV/REM
    assign w_a_signed = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                        (i_funct3 == 3'b010) || (i_funct3 == 3'b100) ||
                        (i_funct3 == 3'b110);
    assign w_b_signed = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                        (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    assign w_neg1 = w_a_signed & i_num1u[31];
    assign w_neg2 = w_b_signed & i_num2u[31];
    assign w_mag1 = w_neg1 ? (32'd0 - i_num1u) : i_num1u;
    assign w_mag2 = w_neg2 ? (32'd0 - i_num2u) : i_num2u;

    // One shift-add step: add multiplicand if the current multiplier bit is set
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : 33'd0);

    // One restoring-divide step on the 33-bit shifted partial remainder
    assign w_div_shift = {r_hi, r_lo[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
    assign w_div_diff  = w_div_shift[31:0] - r_mcand;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: flush aborts any non-idle state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = i_funct3[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (i_flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == C_LAST_ITER) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Busy output: anything but IDLE holds the pipeline
    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    // Sign correction and special cases applied to the finished iteration
    always_comb begin
        w_prod_s = (r_neg1 ^ r_neg2) ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
        w_quot_s = (r_neg1 ^ r_neg2) ? (32'd0 - r_lo) : r_lo;
        w_rem_s  = r_neg1 ? (32'd0 - r_hi) : r_hi;
        w_result = 32'd0;
        case (r_funct3)
            3'b000:                 w_result = w_prod_s[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_s[63:32];
            3'b100, 3'b101: begin
                if (r_div_by_zero)  w_result = 32'hFFFF_FFFF;
                else if (r_ovf)     w_result = 32'h8000_0000;
                else                w_result = w_quot_s;
            end
            default: begin
                if (r_div_by_zero)  w_result = r_num1;
                else if (r_ovf)     w_result = 32'd0;
                else                w_result = w_rem_s;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= 5'd0;
            r_funct3      <= 3'd0;
            r_num1        <= 32'd0;
            r_neg1        <= 1'b0;
            r_neg2        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_ovf         <= 1'b0;
            r_hi          <= 32'd0;
            r_lo          <= 32'd0;
            r_mcand       <= 32'd0;
            r_done        <= 1'b0;
            r_res         <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt         <= 5'd0;
                        r_funct3      <= i_funct3;
                        r_num1        <= i_num1u;
                        r_neg1        <= w_neg1;
                        r_neg2        <= w_neg2;
                        r_div_by_zero <= (i_num2u == 32'd0);
                        r_ovf         <= ((i_funct3 == 3'b100) || (i_funct3 == 3'b110)) &&
                                         (i_num1u == 32'h8000_0000) &&
                                         (i_num2u == 32'hFFFF_FFFF);
                        r_hi          <= 32'd0;
                        r_lo          <= w_mag1;
                        r_mcand       <= w_mag2;
                    end
                end
                S_MUL: begin
                    r_hi  <= w_mul_sum[32:1];
                    r_lo  <= {w_mul_sum[0], r_lo[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_hi  <= w_div_ge ? w_div_diff : w_div_shift[31:0];
                    r_lo  <= {r_lo[30:0], w_div_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DONE: begin
                    if (!i_flush) begin
                        r_done <= 1'b1;
                        r_res  <= w_result;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_done = r_done;
    assign o_res  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_core_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_muldiv
// Brief    : Self-checking bench for core_muldiv; expected results queued at
//            issue and popped at o_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_muldiv;

    localparam logic [6:0] OP_M   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_M   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_flush;
    logic [6:0]  i_opcode;
    logic [6:0]  i_funct7;
    logic [2:0]  i_funct3;
    logic [31:0] i_num1u;
    logic [31:0] i_num2u;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_res;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } op_t;

    op_t         ops[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    int          n_checks = 0;
    int          n_errors = 0;
    time         t_accept;
    time         t_first;

    core_muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_flush  (i_flush),
        .i_opcode (i_opcode),
        .i_funct7 (i_funct7),
        .i_funct3 (i_funct3),
        .i_num1u  (i_num1u),
        .i_num2u  (i_num2u),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_res    (o_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void add_op(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] e);
        op_t o;
        o.f3 = f3; o.a = a; o.b = b; o.e = e;
        ops.push_back(o);
    endfunction

    // Drive a valid M request across one rising edge, then scramble operands
    task automatic start_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] e, input bit push);
        i_start  = 1'b1;
        i_opcode = OP_M;
        i_funct7 = F7_M;
        i_funct3 = f3;
        i_num1u  = a;
        i_num2u  = b;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        t_accept = $time;
        #1;
        i_start  = 1'b0;
        i_funct3 = 3'($urandom);
        i_num1u  = $urandom;
        i_num2u  = $urandom;
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    endtask

    // Wait (bounded) for o_done, check latency, pop the scoreboard and compare
    task automatic wait_done(input string tag, input int lat);
        int cyc = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (o_done) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_latency"}, cyc, lat);
        if (seen) begin
            check({tag, "_sb_depth"}, exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
                last_exp = exp_q.pop_front();
                check({tag, "_res"}, o_res, last_exp);
            end
            check({tag, "_busy_at_done"}, {31'd0, o_busy}, 32'd0);
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (o_done) cnt++;
        end
        check(tag, cnt, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_flush  = 1'b0;
        i_opcode = 7'd0;
        i_funct7 = 7'd0;
        i_funct3 = 3'd0;
        i_num1u  = 32'd0;
        i_num2u  = 32'd0;
        last_exp = 32'd0;

        add_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB); // MUL
        add_op(3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF); // MULH
        add_op(3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006); // MULHU
        add_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006); // MULHSU
        add_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); // MULH
        add_op(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000); // MUL
        add_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); // MULHSU
        add_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD); // DIV
        add_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF); // REM
        add_op(3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC); // DIVU
        add_op(3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001); // REMU
        add_op(3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF); // DIV by 0
        add_op(3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005); // REMU by 0
        add_op(3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF); // DIVU by 0
        add_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9); // REM by 0
        add_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); // DIV overflow
        add_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000); // REM overflow
        add_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); // MULHU max

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_res",  o_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operation table; each done pulse must be one cycle wide
        for (int k = 0; k < ops.size(); k++) begin
            @(negedge clk);
            start_op($sformatf("op%0d", k), ops[k].f3, ops[k].a, ops[k].b, ops[k].e, 1'b1);
            wait_done($sformatf("op%0d", k), 33);
            @(posedge clk);
            #1;
            check($sformatf("op%0d_done_width", k), {31'd0, o_done}, 32'd0);
            check($sformatf("op%0d_res_hold", k), o_res, last_exp);
        end

        // Second start while busy is ignored
        @(negedge clk);
        start_op("busy_start", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        i_start  = 1'b1;
        i_opcode = OP_M;
        i_funct7 = F7_M;
        i_funct3 = 3'b000;
        i_num1u  = 32'd3;
        i_num2u  = 32'd4;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done("busy_start", 27);
        expect_quiet("busy_start_no_second_done", 40);

        // Non-M opcode and wrong funct7 are not accepted
        @(negedge clk);
        i_start  = 1'b1;
        i_opcode = OP_IMM;
        i_funct7 = F7_M;
        @(posedge clk);
        #1;
        check("bad_opcode_busy", {31'd0, o_busy}, 32'd0);
        i_opcode = OP_M;
        i_funct7 = 7'b0000000;
        @(posedge clk);
        #1;
        check("bad_funct7_busy", {31'd0, o_busy}, 32'd0);
        i_start = 1'b0;
        expect_quiet("bad_start_no_done", 40);

        // Back-to-back: next start accepted on the edge after the done cycle
        @(negedge clk);
        start_op("b2b_a", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        t_first = t_accept;
        wait_done("b2b_a", 33);
        start_op("b2b_b", 3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 1'b1);
        check("b2b_spacing", 32'(t_accept - t_first), 32'd340);
        wait_done("b2b_b", 33);

        // Flush on iteration 10: no done, result held, then a fresh MUL
        @(negedge clk);
        start_op("flush", 3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check("flush_done", {31'd0, o_done}, 32'd0);
        check("flush_busy", {31'd0, o_busy}, 32'd0);
        expect_quiet("flush_no_done", 40);
        check("flush_res_held", o_res, 32'h0000_0001);
        @(negedge clk);
        start_op("post_flush", 3'b000, 32'd3, 32'd4, 32'h0000_000C, 1'b1);
        wait_done("post_flush", 33);

        // Flush together with start in IDLE: start wins
        @(negedge clk);
        i_flush = 1'b1;
        start_op("flush_start", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
        i_flush = 1'b0;
        wait_done("flush_start", 33);

        // Asynchronous reset mid-DIV
        @(negedge clk);
        start_op("rst_mid", 3'b100, 32'd100, 32'd7, 32'd0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        check("rst_mid_done", {31'd0, o_done}, 32'd0);
        check("rst_mid_res",  o_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("rst_mid_no_done", 40);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
